// File: rtl/hazard_scoreboard.sv
// Issue-side hazard scoreboard: tracks in-flight register writes by latency class and
// stalls/bubbles the ID instruction when an operand cannot yet be forwarded.
`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE 4:0
`endif

module hazard_scoreboard #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [`GPR_ADDR_SPACE] id_rs1_addr,
    input  logic                   id_rs1_re,
    input  logic [`GPR_ADDR_SPACE] id_rs2_addr,
    input  logic                   id_rs2_re,
    input  logic                   id_is_branch,
    input  logic [`GPR_ADDR_SPACE] id_rd_addr,
    input  logic                   id_rd_we,
    input  logic [1:0]             id_lat_class,
    input  logic                   flush_exe,
    input  logic                   div_done,
    input  logic [`GPR_ADDR_SPACE] div_rd_addr,
    output logic                   stall_pc,
    output logic                   stall_if_id,
    output logic                   bubble_id_exe,
    output logic [31:0]            sb_busy
);

    typedef enum logic [1:0] {
        LatAlu  = 2'b00,
        LatLoad = 2'b01,
        LatMul  = 2'b10,
        LatDiv  = 2'b11
    } lat_class_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMul = CNT_W'(MUL_LAT - 1);

    logic [31:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]            lbusy_q, lbusy_d;
    logic [`GPR_ADDR_SPACE] ex_rd_q, mem_ld_rd_q;
    logic                   ex_v_q, ex_ld_q, mem_ld_v_q;

    logic [31:0] busy;
    logic        br_blk1, br_blk2;
    logic        rs1_haz, rs2_haz, waw_haz;
    logic        stall, issue, rd_wr;
    lat_class_e  lat;

    assign lat = lat_class_e'(id_lat_class);

    always_comb begin
        busy = '0;
        for (int r = 1; r < 32; r++) begin
            busy[r] = (cnt_q[r] != '0) || lbusy_q[r];
        end
    end

    assign sb_busy = busy;

    // Branches resolve in ID and only see EXE_MEM ALU results, not load or MEM_WB data.
    assign br_blk1 = (ex_v_q && (id_rs1_addr == ex_rd_q)) ||
                     (mem_ld_v_q && (id_rs1_addr == mem_ld_rd_q));
    assign br_blk2 = (ex_v_q && (id_rs2_addr == ex_rd_q)) ||
                     (mem_ld_v_q && (id_rs2_addr == mem_ld_rd_q));

    assign rs1_haz = id_rs1_re && (id_rs1_addr != '0) &&
                     (busy[id_rs1_addr] || (id_is_branch && br_blk1));
    assign rs2_haz = id_rs2_re && (id_rs2_addr != '0) &&
                     (busy[id_rs2_addr] || (id_is_branch && br_blk2));
    assign waw_haz = id_rd_we && (id_rd_addr != '0) && busy[id_rd_addr];

    assign stall         = id_valid && (rs1_haz || rs2_haz || waw_haz);
    assign stall_pc      = stall;
    assign stall_if_id   = stall;
    assign bubble_id_exe = stall;

    assign issue = id_valid && !stall;
    assign rd_wr = issue && id_rd_we && (id_rd_addr != '0);

    // Priority: new issue > flush of ID_EXE > divider completion / countdown.
    always_comb begin
        lbusy_d = lbusy_q;
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CntOne : '0;
        end
        if (div_done) begin
            lbusy_d[div_rd_addr] = 1'b0;
        end
        if (flush_exe && ex_v_q) begin
            cnt_d[ex_rd_q]   = '0;
            lbusy_d[ex_rd_q] = 1'b0;
        end
        if (rd_wr) begin
            unique case (lat)
                LatAlu:  cnt_d[id_rd_addr]   = '0;
                LatLoad: cnt_d[id_rd_addr]   = CntOne;
                LatMul:  cnt_d[id_rd_addr]   = CntMul;
                LatDiv:  lbusy_d[id_rd_addr] = 1'b1;
            endcase
        end
        cnt_d[0]   = '0;
        lbusy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            lbusy_q     <= '0;
            ex_rd_q     <= '0;
            ex_v_q      <= 1'b0;
            ex_ld_q     <= 1'b0;
            mem_ld_rd_q <= '0;
            mem_ld_v_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            lbusy_q     <= lbusy_d;
            ex_rd_q     <= id_rd_addr;
            ex_v_q      <= rd_wr;
            ex_ld_q     <= (lat == LatLoad);
            mem_ld_rd_q <= ex_rd_q;
            mem_ld_v_q  <= ex_v_q && ex_ld_q && !flush_exe;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus randomized traffic checked
// against a ready-time model of register availability.
module tb_hazard_scoreboard;

    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned CNT_W   = 3;
    localparam int ALU = 0, LD = 1, MUL = 2, DIV = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, div_rd_addr;
    logic        id_rs1_re, id_rs2_re, id_is_branch, id_rd_we;
    logic [1:0]  id_lat_class;
    logic        flush_exe, div_done;
    logic        stall_pc, stall_if_id, bubble_id_exe;
    logic [31:0] sb_busy;

    hazard_scoreboard #(
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs1_re     (id_rs1_re),
        .id_rs2_addr   (id_rs2_addr),
        .id_rs2_re     (id_rs2_re),
        .id_is_branch  (id_is_branch),
        .id_rd_addr    (id_rd_addr),
        .id_rd_we      (id_rd_we),
        .id_lat_class  (id_lat_class),
        .flush_exe     (flush_exe),
        .div_done      (div_done),
        .div_rd_addr   (div_rd_addr),
        .stall_pc      (stall_pc),
        .stall_if_id   (stall_if_id),
        .bubble_id_exe (bubble_id_exe),
        .sb_busy       (sb_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: earliest cycle a normal / branch consumer may read each register.
    int cyc;
    int nb_ready[32];
    int br_ready[32];
    bit div_pend[32];
    bit last_v;
    int last_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc    = 0;
        last_v = 1'b0;
        last_rd = 0;
        for (int r = 0; r < 32; r++) begin
            nb_ready[r] = 0;
            br_ready[r] = 0;
            div_pend[r] = 1'b0;
        end
    endtask

    function automatic bit src_haz(input logic [4:0] a, input logic re, input logic br);
        if (!re || a == 5'd0) return 1'b0;
        return div_pend[a] || (cyc < (br ? br_ready[a] : nb_ready[a]));
    endfunction

    function automatic bit model_stall();
        bit waw;
        waw = id_rd_we && (id_rd_addr != 5'd0) &&
              (div_pend[id_rd_addr] || cyc < nb_ready[id_rd_addr]);
        return id_valid && (src_haz(id_rs1_addr, id_rs1_re, id_is_branch) ||
                            src_haz(id_rs2_addr, id_rs2_re, id_is_branch) || waw);
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        for (int r = 1; r < 32; r++) b[r] = div_pend[r] || (cyc < nb_ready[r]);
        return b;
    endfunction

    task automatic model_edge(input bit issue);
        int c = cyc;
        int r;
        int m;
        if (div_done) div_pend[div_rd_addr] = 1'b0;
        if (flush_exe && last_v) begin
            if (nb_ready[last_rd] > c + 1) nb_ready[last_rd] = c + 1;
            if (br_ready[last_rd] > c + 1) br_ready[last_rd] = c + 1;
            div_pend[last_rd] = 1'b0;
        end
        last_v = 1'b0;
        if (issue && id_rd_we && id_rd_addr != 5'd0) begin
            r       = int'(id_rd_addr);
            last_v  = 1'b1;
            last_rd = r;
            case (int'(id_lat_class))
                ALU: begin nb_ready[r] = c + 1; br_ready[r] = c + 2; end
                LD:  begin nb_ready[r] = c + 2; br_ready[r] = c + 3; end
                MUL: begin
                    m = c + int'(MUL_LAT);
                    nb_ready[r] = m;
                    br_ready[r] = (m > c + 2) ? m : c + 2;
                end
                default: begin div_pend[r] = 1'b1; nb_ready[r] = c + 1; br_ready[r] = c + 2; end
            endcase
        end
        cyc++;
    endtask

    task automatic set_idle();
        id_valid = 0; id_rs1_addr = '0; id_rs1_re = 0; id_rs2_addr = '0; id_rs2_re = 0;
        id_is_branch = 0; id_rd_addr = '0; id_rd_we = 0; id_lat_class = '0;
        flush_exe = 0; div_done = 0; div_rd_addr = '0;
    endtask

    task automatic set_instr(input int rs1, input bit re1, input int rs2, input bit re2,
                             input bit br, input int rd, input bit we, input int cls);
        id_valid = 1; id_rs1_addr = 5'(rs1); id_rs1_re = re1; id_rs2_addr = 5'(rs2);
        id_rs2_re = re2; id_is_branch = br; id_rd_addr = 5'(rd); id_rd_we = we;
        id_lat_class = 2'(cls);
    endtask

    // One clock: check outputs at the negedge, then advance the model at the posedge.
    task automatic do_cycle(input string tag, output logic s, output logic [31:0] b);
        bit          es;
        logic [31:0] eb;
        @(negedge clk);
        es = model_stall();
        eb = model_busy();
        chk({tag, "/stall_pc"}, 32'(stall_pc), 32'(es));
        chk({tag, "/stall_if_id"}, 32'(stall_if_id), 32'(es));
        chk({tag, "/bubble"}, 32'(bubble_id_exe), 32'(es));
        chk({tag, "/sb_busy"}, sb_busy, eb);
        s = stall_pc;
        b = sb_busy;
        @(posedge clk);
        model_edge(id_valid && !es);
        #1;
    endtask

    task automatic issue_until(input string tag, input int exp_stalls);
        int          n = 0;
        logic        s;
        logic [31:0] b;
        for (int i = 0; i < 20; i++) begin
            do_cycle(tag, s, b);
            if (s !== 1'b1) break;
            n++;
        end
        chk({tag, "/stall_cycles"}, 32'(n), 32'(exp_stalls));
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        s;
        logic [31:0] b;
        int          pend[$];

        set_idle();
        model_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset/stall_pc", 32'(stall_pc), 32'd0);
        chk("reset/sb_busy", sb_busy, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_cycle("idle", s, b);

        // Load-use: exactly one bubble.
        set_instr(0, 0, 0, 0, 0, 5, 1, LD);  issue_until("ld_x5", 0);
        set_instr(5, 1, 1, 1, 0, 6, 1, ALU); issue_until("load_use", 1);

        // ALU -> ALU: no bubble.
        set_instr(1, 1, 2, 1, 0, 3, 1, ALU); issue_until("alu_x3", 0);
        set_instr(3, 1, 3, 1, 0, 4, 1, ALU); issue_until("alu_alu", 0);

        // Branch after ALU: one stall; after LOAD: two stalls.
        set_instr(0, 0, 0, 0, 0, 7, 1, ALU); issue_until("alu_x7", 0);
        set_instr(7, 1, 0, 1, 1, 0, 0, ALU); issue_until("br_after_alu", 1);
        set_instr(0, 0, 0, 0, 0, 7, 1, LD);  issue_until("ld_x7", 0);
        set_instr(7, 1, 0, 1, 1, 0, 0, ALU); issue_until("br_after_ld", 2);

        // MUL: two stalls with x8 busy for exactly those two cycles.
        set_instr(0, 0, 0, 0, 0, 8, 1, MUL); issue_until("mul_x8", 0);
        set_instr(8, 1, 0, 1, 0, 9, 1, ALU);
        do_cycle("mul_use0", s, b); chk("mul_use0/s", 32'(s), 32'd1); chk("mul_use0/b8", 32'(b[8]), 32'd1);
        do_cycle("mul_use1", s, b); chk("mul_use1/s", 32'(s), 32'd1); chk("mul_use1/b8", 32'(b[8]), 32'd1);
        do_cycle("mul_use2", s, b); chk("mul_use2/s", 32'(s), 32'd0); chk("mul_use2/b8", 32'(b[8]), 32'd0);
        set_idle();

        // DIV consumer released the cycle after div_done.
        set_instr(0, 0, 0, 0, 0, 10, 1, DIV); issue_until("div_x10", 0);
        set_instr(10, 1, 0, 0, 0, 11, 1, ALU);
        for (int i = 0; i < 3; i++) begin
            do_cycle("div_wait", s, b); chk("div_wait/s", 32'(s), 32'd1);
        end
        div_done = 1; div_rd_addr = 5'd10;
        do_cycle("div_done_cyc", s, b); chk("div_done_cyc/s", 32'(s), 32'd1);
        div_done = 0;
        do_cycle("div_release", s, b); chk("div_release/s", 32'(s), 32'd0);
        set_idle();

        // WAW against a pending DIV.
        set_instr(0, 0, 0, 0, 0, 10, 1, DIV); issue_until("div2_x10", 0);
        set_instr(0, 0, 0, 0, 0, 10, 1, ALU);
        for (int i = 0; i < 2; i++) begin
            do_cycle("waw_wait", s, b); chk("waw_wait/s", 32'(s), 32'd1);
        end
        div_done = 1; div_rd_addr = 5'd10;
        do_cycle("waw_done", s, b); chk("waw_done/s", 32'(s), 32'd1);
        div_done = 0;
        do_cycle("waw_release", s, b); chk("waw_release/s", 32'(s), 32'd0);
        set_idle();

        // Flushed LOAD: consumer issues without stall and x11 reads idle.
        set_instr(0, 0, 0, 0, 0, 11, 1, LD); issue_until("ld_x11", 0);
        flush_exe = 1;
        do_cycle("flush_ld", s, b);
        flush_exe = 0;
        set_instr(11, 1, 0, 1, 0, 12, 1, ALU);
        do_cycle("flush_use", s, b); chk("flush_use/s", 32'(s), 32'd0); chk("flush_use/b11", 32'(b[11]), 32'd0);
        set_idle();

        // Flushed LOAD seen by a branch: the MEM-stage load hazard disappears.
        set_instr(0, 0, 0, 0, 0, 14, 1, LD); issue_until("ld_x14", 0);
        set_instr(14, 1, 0, 0, 1, 0, 0, ALU);
        flush_exe = 1;
        do_cycle("flush_br0", s, b); chk("flush_br0/s", 32'(s), 32'd1);
        flush_exe = 0;
        do_cycle("flush_br1", s, b); chk("flush_br1/s", 32'(s), 32'd0);
        set_idle();

        // Asynchronous reset in the middle of DIV x5 / MUL x6.
        set_instr(0, 0, 0, 0, 0, 5, 1, DIV); issue_until("div_x5", 0);
        set_instr(0, 0, 0, 0, 0, 6, 1, MUL); issue_until("mul_x6", 0);
        set_instr(5, 1, 6, 1, 0, 13, 1, ALU);
        @(negedge clk);
        chk("pre_rst/stall", 32'(stall_pc), 32'd1);
        chk("pre_rst/sb_busy", sb_busy, 32'h0000_0060);
        rst_n = 1'b0;
        #1;
        chk("mid_rst/stall_pc", 32'(stall_pc), 32'd0);
        chk("mid_rst/stall_if_id", 32'(stall_if_id), 32'd0);
        chk("mid_rst/bubble", 32'(bubble_id_exe), 32'd0);
        chk("mid_rst/sb_busy", sb_busy, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
        model_reset();
        @(posedge clk);
        #1;
        do_cycle("post_rst", s, b);

        // Randomized traffic on a small register window to force frequent hazards.
        for (int i = 0; i < 400; i++) begin
            bit br;
            set_idle();
            if ($urandom_range(99) < 85) begin
                br = ($urandom_range(4) == 0);
                set_instr(int'($urandom_range(7)), 1'($urandom_range(1)),
                          int'($urandom_range(7)), 1'($urandom_range(1)), br,
                          int'($urandom_range(7)), br ? 1'b0 : ($urandom_range(4) != 0),
                          int'($urandom_range(3)));
            end
            if (last_v && $urandom_range(9) == 0) flush_exe = 1;
            pend = {};
            for (int r = 1; r < 8; r++) if (div_pend[r]) pend.push_back(r);
            if (pend.size() != 0 && $urandom_range(3) == 0) begin
                div_done    = 1;
                div_rd_addr = 5'(pend[$urandom_range(pend.size() - 1)]);
            end
            do_cycle("rand", s, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer side of operand bypassing: decides whether the instruction in ID may issue into ID_EXE.
- The forwarding logic only delivers values. This block tracks in-flight register writes per latency class and raises stall/bubble when a value cannot yet be forwarded.
- Sits beside the ID stage. Drives PC/IF_ID hold and ID_EXE bubble insertion.

Parameters:
- MUL_LAT, 3: EXE cycles of a pipelined multiply before its result reaches EXE_MEM (≥1).
- CNT_W, 3: width of per-register countdown (must hold MUL_LAT-1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  valid instruction in ID
- id_rs1_addr  in  `GPR_ADDR_SPACE  ID source 1
- id_rs1_re  in  1  source 1 read
- id_rs2_addr  in  `GPR_ADDR_SPACE  ID source 2
- id_rs2_re  in  1  source 2 read
- id_is_branch  in  1  ID instruction resolves a branch in ID
- id_rd_addr  in  `GPR_ADDR_SPACE  ID destination
- id_rd_we  in  1  ID writes rd
- id_lat_class  in  2  00 ALU, 01 LOAD, 10 MUL, 11 DIV
- flush_exe  in  1  kill instruction currently in ID_EXE
- div_done  in  1  divider writes result this cycle
- div_rd_addr  in  `GPR_ADDR_SPACE  divider destination
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF_ID
- bubble_id_exe  out  1  load NOP into ID_EXE
- sb_busy  out  32  per-register pending bit (debug); bit 0 always 0

Behaviour:
- State, all registered:
  - cnt[r] (CNT_W): remaining bubbles before a non-branch consumer of r may issue.
  - lbusy[r]: long-latency (DIV) pending.
  - ex_rd / ex_v: destination of the instruction issued last cycle.
  - mem_ld_rd / mem_ld_v: load now in MEM.
- Reset (rst_n low, asynchronous): all cnt=0, lbusy=0, ex_v=0, mem_ld_v=0. Hence stall_pc=stall_if_id=bubble_id_exe=0 and sb_busy=0 while in reset.
- Source hazard, per used source s (re=1, addr≠0), evaluated on registered state only:
  - Any consumer: hazard if cnt[s]≠0 or lbusy[s].
  - Branch consumer: additionally hazard if (ex_v & s==ex_rd) or (mem_ld_v & s==mem_ld_rd). Branches receive EXE_MEM ALU values only, never load data or MEM_WB values.
- WAW hazard: id_rd_we & id_rd_addr≠0 & (cnt[rd]≠0 or lbusy[rd]).
- Outputs:
  - stall = id_valid & (source hazard | WAW hazard).
  - stall_pc = stall_if_id = bubble_id_exe = stall. Purely combinational from state plus ID inputs, no added latency.
- issue = id_valid & ~stall. On issue with id_rd_we & rd≠0:
  - ALU: cnt=0.
  - LOAD: cnt=1.
  - MUL: cnt=MUL_LAT-1.
  - DIV: lbusy=1.
  - ex_rd<=rd, ex_v<=1. If no issue or no write, ex_v<=0.
- mem_ld_v <= ex_v & (ex class was LOAD) & ~flush_exe; mem_ld_rd <= ex_rd.
- Every cycle, each nonzero cnt decrements by 1, saturating at 0. Same-cycle set on issue overrides the decrement.
- div_done clears lbusy[div_rd_addr] at the clock edge. The stall decision that same cycle still sees lbusy=1; a dependent issues the following cycle.
- flush_exe: clears cnt[ex_rd], lbusy[ex_rd] and ex_v. Safe because WAW stalling guarantees no older write to that rd is pending. If flush_exe and a new issue to the same rd coincide, the new issue wins.
- Register x0 is never tracked: writes are ignored and reads never hazard.
- Simultaneous div_done and DIV issue to the same rd: impossible, because WAW stalls the issue.
- sb_busy[r] = (cnt[r]≠0) | lbusy[r].

Test Plan:
- Reset mid-operation: lbusy[5]=1 and cnt[6]=2, pulse rst_n low asynchronously → sb_busy=0 and all stall outputs 0 immediately, before the next clk edge.
- Load-use: LOAD x5, next cycle ADD x6,x5,x1 → exactly 1 stall cycle, then issue. Back-to-back ALU producer/consumer → 0 stalls.
- Branch after ALU: ADD x7 then BEQ x7,x0 → 1 stall. Branch after LOAD x7 → 2 stalls.
- MUL_LAT=3: MUL x8 then ADD x9,x8,x0 → 2 stalls, sb_busy[8] high for 2 cycles.
- DIV x10, consumer waiting: div_done asserted with div_rd_addr=10 at cycle N → stall still high in cycle N, consumer issues in N+1. DIV to x10 followed by ALU write to x10 → WAW stall until div_done.
- flush_exe on the cycle after LOAD x11 issues → sb_busy[11]=0 next cycle; ADD x12,x11 issues with no stall.
